hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parameterised pipeline stall/flush controller for an in-order pipeline of `NREG` pipeline registers.
- Combines per-stage hold requests, a counted decode-stage stall and a branch/jump redirect into a single set of controls: PC enable, per-register enable and per-register flush.
- Register `j` sits between stage `j` and stage `j+1`. Stage 0 is fetch. Register 0 is IF/ID and register `NREG-1` is MEM/WB.

## Interface
Parameters:
- `NREG`, 4: number of pipeline registers; must be ≥ 2.
- `CNT_W`, 3: width of the counted-stall length.
- `DSTG`, 1: stage index that receives counted stalls; 1 ≤ `DSTG` < `RSTG`.
- `RSTG`, 2: stage index that issues redirects; `RSTG` < `NREG`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `hold_req` in `NREG`: bit `s` means stage `s` cannot advance this cycle (level).
- `ld_stall_cnt` in `CNT_W`: counted-stall length N for stage `DSTG`; 0 = none.
- `redirect` in 1: stage `RSTG` resolved a taken control transfer; held until acked.
- `pc_en` out 1: PC register load enable.
- `reg_en` out `NREG`: pipeline register load enables.
- `reg_flush` out `NREG`: load a bubble; overrides `reg_en`.
- `redirect_ack` out 1: redirect accepted this cycle.
- `cnt_busy` out 1: FSM is in COUNT.

## Operation
Outputs are combinational from the inputs and registered state; state updates on the rising edge of `clk`.

State:
- FSM: IDLE or COUNT.
- `cnt` (`CNT_W` bits).

Definitions:
- `Kh` = highest set index of `hold_req`.
- Stage `s` is *frozen* when `Kh > s`.
- Acceptance: `redirect_ack = redirect & ~(any hold_req[NREG-1:RSTG])`.
- Counted stall active: `~redirect_ack & (COUNT | (IDLE & ld_stall_cnt≠0 & ~frozen(DSTG)))`.
- `K` = max(`Kh`, `DSTG` when counted stall active). `K` is undefined when nothing holds.

Output rules, in priority order:
- **Redirect acked:**
  - `pc_en`=1.
  - `reg_flush[j]`=1 and `reg_en[j]`=1 for `j < RSTG`.
  - Other registers: `reg_en`=1, `reg_flush`=0.
  - `hold_req` bits below `RSTG` are ignored.
- **Hold at K:**
  - `pc_en`=0.
  - `reg_en[j]`=0 for `j < K`.
  - `reg_en[K]`=0 and `reg_flush[K]`=1.
  - `reg_en[j]`=1 and `reg_flush`=0 for `j > K`.
- **Otherwise:** `pc_en`=1, `reg_en` all 1, `reg_flush` all 0.

FSM:
- IDLE, counted stall starts, not frozen:
  - `cnt` ← N−1.
  - Next state is COUNT if N > 1, else stays IDLE.
  - This cycle is stall cycle 1.
- IDLE, stage `DSTG` frozen: `ld_stall_cnt` is not loaded. The detector keeps presenting it until it is taken.
- COUNT: `ld_stall_cnt` is ignored.
  - If not frozen: `cnt` ← `cnt`−1; when `cnt`==1, go to IDLE.
  - If frozen: `cnt` holds.
- Redirect acked in COUNT: `cnt` ← 0, next state IDLE; the stall is cancelled.
- After the last stall cycle, the hazard detector must present 0 for the released instruction.

## Timing
- Reset (`rst`=0):
  - FSM=IDLE, `cnt`=0.
  - Outputs forced: `pc_en`=1, `reg_en` all 1, `reg_flush` all 0, `redirect_ack`=0, `cnt_busy`=0.
- Zero-cycle latency from `hold_req` / `redirect` to outputs.
- A counted stall of N holds exactly N unfrozen cycles; frozen cycles extend it.
- Simultaneous redirect and hold:
  - Hold at index ≥ `RSTG`: redirect not acked; the source retries.
  - Hold below `RSTG`: redirect wins.
- Reset asserted mid-COUNT: aborts to IDLE immediately.

## Configuration
- `STALL_PERF_EN` defined:
  - Adds output `perf_stall_cycles` [31:0].
  - Increments every cycle that `rst`=1 and `pc_en`=0; saturates at 0xFFFFFFFF.
  - Reset value 0.
- `STALL_PERF_EN` undefined: the port and the counter do not exist.

## Test plan
All scenarios use default parameters.
- **Reset:** `rst` low for 3 cycles with `redirect`=1 and `hold_req`=4'hF → `pc_en`=1, `reg_en`=4'hF, `reg_flush`=0, `redirect_ack`=0.
- **Counted stall:** `ld_stall_cnt`=3 in IDLE →
  - 3 cycles of `pc_en`=0, `reg_en`=4'b1100, `reg_flush`=4'b0010.
  - `cnt_busy`=1 on cycles 2–3.
  - Then all enables return to 1.
- **Memory hold then counted stall:** `hold_req`=4'b1000 for 2 cycles while `ld_stall_cnt`=2 →
  - Cycles 1–2: `reg_en`=4'b0000, `reg_flush`=4'b1000, no load.
  - Cycles 3–4: the decode stall pattern.
- **Redirect cancels stall:** `redirect` on the 2nd cycle of a 4-cycle counted stall →
  - `redirect_ack`=1, `pc_en`=1, `reg_flush`=4'b0011.
  - Next cycle: IDLE, `cnt_busy`=0.
- **Redirect blocked:** `redirect` while `hold_req[3]`=1 for 3 cycles →
  - `redirect_ack`=0 for 3 cycles.
  - Acked on cycle 4 with `reg_flush`=4'b0011.
- **Perf counter (`STALL_PERF_EN`):** 5 stall cycles plus 1 redirect cycle → `perf_stall_cycles`=5.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
// Bundles the hazard-detector side and the pipeline-control side of the
// stall/flush controller.
//   master : hazard detector / pipeline (drives requests, receives controls)
//   slave  : hazard_stall_ctrl (receives requests, drives controls)
// Signals:
//   hold_req[NREG]     stage s cannot advance this cycle (level)
//   ld_stall_cnt[CNT_W] counted-stall length for the decode stage, 0 = none
//   redirect           taken control transfer from the redirect stage
//   pc_en, reg_en, reg_flush  pipeline controls (flush overrides enable)
//   redirect_ack       redirect accepted this cycle
//   cnt_busy           counted stall in progress (controller state visible)
// Handshake: redirect behaves as a valid and redirect_ack as its ready; the
// source keeps redirect asserted and unchanged until it sees redirect_ack
// high in the same cycle, and the transfer completes on that clock edge.
interface hazard_stall_ctrl_if #(
  parameter int NREG  = 4,
  parameter int CNT_W = 3
);
  logic [NREG-1:0]  hold_req;
  logic [CNT_W-1:0] ld_stall_cnt;
  logic             redirect;
  logic             pc_en;
  logic [NREG-1:0]  reg_en;
  logic [NREG-1:0]  reg_flush;
  logic             redirect_ack;
  logic             cnt_busy;

  modport master (
    output hold_req, ld_stall_cnt, redirect,
    input  pc_en, reg_en, reg_flush, redirect_ack, cnt_busy
  );

  modport slave (
    input  hold_req, ld_stall_cnt, redirect,
    output pc_en, reg_en, reg_flush, redirect_ack, cnt_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Stall/flush controller for an in-order pipeline of NREG pipeline registers.
// Register j sits between stage j and stage j+1; stage 0 is fetch.
// Merges per-stage hold requests, a counted decode-stage stall and a
// redirect from stage RSTG into PC enable, per-register enable and flush.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous, active-low reset
//   bus   : hazard_stall_ctrl_if.slave (requests in, controls out)
//   perf_stall_cycles[31:0] : saturating count of pc_en=0 cycles, present
//                             only when STALL_PERF_EN is defined
// Optional feature macro: STALL_PERF_EN
module hazard_stall_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 3,
  parameter int DSTG  = 1,
  parameter int RSTG  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_stall_ctrl_if.slave    bus
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int              KW      = (NREG > 2) ? $clog2(NREG) : 1;
  localparam logic [KW-1:0]   DSTG_K  = KW'(DSTG);
  localparam logic [NREG-1:0] RFLUSH  = NREG'((1 << RSTG) - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [KW-1:0]    w_kh;
  logic             w_kh_vld;
  logic             w_frozen_d;
  logic             w_ack;
  logic             w_cnt_act;
  logic             w_hold;
  logic [KW-1:0]    w_k;

  // Highest holding stage; every stage below it is frozen.
  always_comb begin
    w_kh     = '0;
    w_kh_vld = 1'b0;
    for (int s = 0; s < NREG; s++) begin
      if (bus.hold_req[s]) begin
        w_kh     = s[KW-1:0];
        w_kh_vld = 1'b1;
      end
    end
  end

  assign w_frozen_d = w_kh_vld && (w_kh > DSTG_K);
  // Holds at or beyond the redirect stage block the redirect; holds in
  // younger stages are discarded because those stages get flushed anyway.
  assign w_ack      = bus.redirect && !(|bus.hold_req[NREG-1:RSTG]);
  assign w_cnt_act  = !w_ack &&
                      ((r_state == COUNT) ||
                       ((r_state == IDLE) && (bus.ld_stall_cnt != '0) && !w_frozen_d));
  assign w_hold     = w_kh_vld || w_cnt_act;
  assign w_k        = (w_cnt_act && (!w_kh_vld || (w_kh < DSTG_K))) ? DSTG_K : w_kh;

  always_comb begin
    bus.pc_en        = 1'b1;
    bus.reg_en       = '1;
    bus.reg_flush    = '0;
    bus.redirect_ack = 1'b0;
    bus.cnt_busy     = 1'b0;
    if (rst) begin
      bus.redirect_ack = w_ack;
      bus.cnt_busy     = (r_state == COUNT);
      if (w_ack) begin
        bus.reg_flush = RFLUSH;
      end else if (w_hold) begin
        // Register K takes a bubble, older registers drain, younger freeze.
        bus.pc_en = 1'b0;
        for (int j = 0; j < NREG; j++) begin
          bus.reg_en[j]    = (j > int'(w_k));
          bus.reg_flush[j] = (j == int'(w_k));
        end
      end
    end
  end

  // r_cnt holds the stall cycles still owed after the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cnt_act) begin
            r_cnt   <= bus.ld_stall_cnt - CNT_W'(1);
            r_state <= (bus.ld_stall_cnt > CNT_W'(1)) ? COUNT : IDLE;
          end
        end
        COUNT: begin
          if (w_ack) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!w_frozen_d) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (!bus.pc_en && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int NREG  = 4;
  localparam int CNT_W = 3;
  localparam int DSTG  = 1;
  localparam int RSTG  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.NREG(NREG), .CNT_W(CNT_W)) bus ();

`ifdef STALL_PERF_EN
  logic [31:0] perf;
`endif

  hazard_stall_ctrl #(.NREG(NREG), .CNT_W(CNT_W), .DSTG(DSTG), .RSTG(RSTG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STALL_PERF_EN
    ,
    .perf_stall_cycles (perf)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Observation order: {pc_en, reg_en, reg_flush, redirect_ack, cnt_busy}
  localparam logic [10:0] O_FREE  = {1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
  localparam logic [10:0] O_DEC0  = {1'b0, 4'b1100, 4'b0010, 1'b0, 1'b0};
  localparam logic [10:0] O_DEC1  = {1'b0, 4'b1100, 4'b0010, 1'b0, 1'b1};
  localparam logic [10:0] O_MEM   = {1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0};

  function automatic logic [10:0] obs();
    return {bus.pc_en, bus.reg_en, bus.reg_flush, bus.redirect_ack, bus.cnt_busy};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [3:0] h, input logic [2:0] l, input logic rd);
    @(negedge clk);
    rst              = r;
    bus.hold_req     = h;
    bus.ld_stall_cnt = l;
    bus.redirect     = rd;
    #1;
  endtask

  // ---------------- reference model ----------------
  // m_rem: unfrozen stall cycles still owed by the counted stall (0 = none).
  int m_rem = 0;
  logic [10:0] exp_q[$];

  task automatic model_step(input logic r, input logic [3:0] h, input logic [2:0] l, input logic rd);
    int   kh, k;
    logic hi, ack, frozen, active;
    logic epc, eack, ebusy;
    logic [3:0] een, efl;
    kh = -1;
    hi = 1'b0;
    for (int s = 0; s < NREG; s++) begin
      if (h[s]) kh = s;
      if (h[s] && s >= RSTG) hi = 1'b1;
    end
    ack    = rd && !hi;
    frozen = (kh > DSTG);
    active = !ack && ((m_rem > 0) || ((l != 0) && !frozen));
    k = kh;
    if (active && DSTG > k) k = DSTG;
    epc = 1'b1; een = 4'hF; efl = 4'h0; eack = 1'b0; ebusy = 1'b0;
    if (r) begin
      eack  = ack;
      ebusy = (m_rem > 0);
      if (ack) begin
        for (int j = 0; j < RSTG; j++) efl[j] = 1'b1;
      end else if (k >= 0) begin
        epc = 1'b0;
        for (int j = 0; j < NREG; j++) begin
          een[j] = (j > k);
          efl[j] = (j == k);
        end
      end
    end
    exp_q.push_back({epc, een, efl, eack, ebusy});
    if (!r) begin
      m_rem = 0;
    end else begin
      if (active && m_rem == 0) m_rem = int'(l);
      if (ack) m_rem = 0;
      else if (active && !frozen) m_rem = m_rem - 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'hF, 3'd0, 1'b1);
      checks++;
      if (obs() !== O_FREE) begin
        failures++;
        $display("FAIL reset_cyc%0d got=%b exp=%b", c, obs(), O_FREE);
      end
    end
    drive(1'b1, 4'h0, 3'd0, 1'b0);
    checks++;
    if (obs() !== O_FREE) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs(), O_FREE);
    end
  endtask

  task automatic test_counted_stall();
    logic [10:0] e [4];
    e = '{O_DEC0, O_DEC1, O_DEC1, O_FREE};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'h0, (c == 0) ? 3'd3 : 3'd0, 1'b0);
      checks++;
      if (obs() !== e[c]) begin
        failures++;
        $display("FAIL counted_stall_cyc%0d got=%b exp=%b", c + 1, obs(), e[c]);
      end
    end
  endtask

  task automatic test_mem_hold();
    logic [10:0] e [5];
    logic [3:0]  h [5];
    logic [2:0]  l [5];
    e = '{O_MEM, O_MEM, O_DEC0, O_DEC1, O_FREE};
    h = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    l = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, h[c], l[c], 1'b0);
      checks++;
      if (obs() !== e[c]) begin
        failures++;
        $display("FAIL mem_hold_cyc%0d got=%b exp=%b", c + 1, obs(), e[c]);
      end
    end
  endtask

  task automatic test_redirect_cancel();
    logic [10:0] e [3];
    e = '{O_DEC0, {1'b1, 4'b1111, 4'b0011, 1'b1, 1'b1}, O_FREE};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'h0, (c == 0) ? 3'd4 : 3'd0, (c == 1));
      checks++;
      if (obs() !== e[c]) begin
        failures++;
        $display("FAIL redirect_cancel_cyc%0d got=%b exp=%b", c + 1, obs(), e[c]);
      end
    end
  endtask

  task automatic test_redirect_blocked();
    logic [10:0] e [5];
    e = '{O_MEM, O_MEM, O_MEM, {1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0}, O_FREE};
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, (c < 3) ? 4'b1000 : 4'b0000, 3'd0, (c < 4));
      checks++;
      if (obs() !== e[c]) begin
        failures++;
        $display("FAIL redirect_blocked_cyc%0d got=%b exp=%b", c + 1, obs(), e[c]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [10:0] e [4];
    logic        r [4];
    e = '{O_DEC0, O_DEC1, O_FREE, O_FREE};
    r = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      drive(r[c], 4'h0, (c == 0) ? 3'd4 : 3'd0, 1'b0);
      checks++;
      if (obs() !== e[c]) begin
        failures++;
        $display("FAIL reset_mid_count_cyc%0d got=%b exp=%b", c + 1, obs(), e[c]);
      end
    end
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    drive(1'b0, 4'h0, 3'd0, 1'b0);
    checks++;
    if (perf !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset got=%0d exp=0", perf);
    end
    for (int c = 0; c < 5; c++) drive(1'b1, 4'h0, (c == 0) ? 3'd5 : 3'd0, 1'b0);
    drive(1'b1, 4'h0, 3'd0, 1'b1);
    drive(1'b1, 4'h0, 3'd0, 1'b0);
    checks++;
    if (perf !== 32'd5) begin
      failures++;
      $display("FAIL perf_count got=%0d exp=5", perf);
    end
  endtask
`endif

  task automatic test_random();
    logic       r, rd;
    logic [3:0] h;
    logic [2:0] l;
    logic [10:0] e;
    drive(1'b0, 4'h0, 3'd0, 1'b0);
    m_rem = 0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 39) != 0);
      h  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      l  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      rd = ($urandom_range(0, 3) == 0);
      drive(r, h, l, rd);
      model_step(r, h, l, rd);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL random_cyc%0d hold=%b ld=%0d redir=%b rst=%b got=%b exp=%b",
                 c, h, l, rd, r, obs(), e);
      end
    end
    drive(1'b1, 4'h0, 3'd0, 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.hold_req     = '0;
    bus.ld_stall_cnt = '0;
    bus.redirect     = 1'b0;
    test_reset();
    test_counted_stall();
    test_mem_hold();
    test_redirect_cancel();
    test_redirect_blocked();
    test_reset_mid_count();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
